// File: rtl/drp_multi_master_if.sv
// DRP bus shared by the multi-channel DRP master and the GTH channels it serves.
// Strobes are one bit per channel. Address and write data are shared by all
// channels. Read data arrives as one 16-bit slice per channel: channel k uses
// drp_do[16k+15:16k].
interface drp_multi_master_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 9
);
  logic [NUM_CH-1:0]    drp_en;
  logic [NUM_CH-1:0]    drp_we;
  logic [ADDR_W-1:0]    drp_addr;
  logic [15:0]          drp_di;
  logic [16*NUM_CH-1:0] drp_do;
  logic [NUM_CH-1:0]    drp_rdy;

  modport master (
    output drp_en, drp_we, drp_addr, drp_di,
    input  drp_do, drp_rdy
  );

  modport slave (
    input  drp_en, drp_we, drp_addr, drp_di,
    output drp_do, drp_rdy
  );
endinterface

// File: rtl/drp_multi_master.sv
// Multi-channel DRP master. It runs read, write and read-modify-write
// transactions on one of NUM_CH GTH channels. The channel is chosen for each
// request. A rising edge of the synchronised req_trigger starts a transaction.
// Optional build macro DRP_TIMEOUT_EN: a wait state gives up after
// TIMEOUT_CYCLES drp_clk cycles without ready and flags err.
module drp_multi_master #(
  parameter int NUM_CH         = 4,
  parameter int ADDR_W         = 9,
  parameter int CH_W           = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              drp_clk,
  input  logic              drp_rst_n,
  input  logic              req_trigger,
  input  logic [1:0]        req_op,
  input  logic [CH_W-1:0]   req_ch,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [15:0]       req_mask,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       rdata,
  drp_multi_master_if.master drp
);

  if ((NUM_CH < 1) || (NUM_CH > 16) || ((2**CH_W) < NUM_CH) || (TIMEOUT_CYCLES < 1))
  begin : g_bad_cfg
    $error("drp_multi_master: inconsistent NUM_CH/CH_W/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_RMW, OP_RSVD} op_t;
  typedef enum logic [2:0] {S_IDLE, S_RD_EN, S_RD_WAIT, S_WR_EN, S_WR_WAIT, S_FIN} state_t;

  localparam logic [31:0] NUM_CH_U = NUM_CH;

  state_t            state_q, state_d;
  op_t               op_q;
  logic              trig_q, armed_q;
  logic [CH_W-1:0]   ch_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q, mask_q, di_q, rdata_q;
  logic              err_q;

  logic              trig_edge, req_bad, sel_rdy, tmo_hit;
  logic [15:0]       sel_do;
  logic [NUM_CH-1:0] ch_oh;

  // armed_q keeps a trigger that is held high through reset release from
  // looking like a fresh edge on the first clock.
  assign trig_edge = armed_q && !trig_q && req_trigger;
  assign req_bad   = (32'(req_ch) >= NUM_CH_U) || (op_t'(req_op) == OP_RSVD);

  // Decode the latched channel into a one-hot strobe and select its rdy/do.
  always_comb begin
    // NOTE: give every combinational output a default first; any path that
    // leaves one unassigned would infer a latch.
    ch_oh   = '0;
    sel_rdy = 1'b0;
    sel_do  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        ch_oh[k] = 1'b1;
        sel_rdy  = drp.drp_rdy[k];
        sel_do   = drp.drp_do[16*k +: 16];
      end
    end
  end

`ifdef DRP_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             in_wait;

  assign in_wait = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
  assign tmo_hit = in_wait && !sel_rdy && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Count completed wait cycles. The count clears in the EN state that always
  // precedes a wait state.
  always_ff @(posedge drp_clk or negedge drp_rst_n) begin
    if (!drp_rst_n)                                    tmo_cnt_q <= '0;
    else if (state_q == S_RD_EN || state_q == S_WR_EN) tmo_cnt_q <= '0;
    else if (in_wait)                                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge drp_clk or negedge drp_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples pre-edge values, whatever order the processes run in.
    if (!drp_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic. Edges outside IDLE are dropped, not queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (trig_edge) begin
        if (req_bad)                           state_d = S_FIN;
        else if (op_t'(req_op) == OP_WRITE)    state_d = S_WR_EN;
        else                                   state_d = S_RD_EN;
      end
      S_RD_EN:   state_d = S_RD_WAIT;
      S_RD_WAIT: if (sel_rdy) state_d = (op_q == OP_RMW) ? S_WR_EN : S_FIN;
                 else if (tmo_hit) state_d = S_FIN;
      S_WR_EN:   state_d = S_WR_WAIT;
      S_WR_WAIT: if (sel_rdy || tmo_hit) state_d = S_FIN;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: strobes go only to the latched channel, one cycle per access.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    drp.drp_en = '0;
    drp.drp_we = '0;
    unique case (state_q)
      S_RD_EN:   begin busy = 1'b1; drp.drp_en = ch_oh; end
      S_WR_EN:   begin busy = 1'b1; drp.drp_en = ch_oh; drp.drp_we = ch_oh; end
      S_RD_WAIT,
      S_WR_WAIT: busy = 1'b1;
      S_FIN:     done = 1'b1;
      default:   ;
    endcase
  end

  // Request latch, edge detect, read capture, RMW merge and the error flag.
  always_ff @(posedge drp_clk or negedge drp_rst_n) begin
    // NOTE: the datapath registers are reset as well as the state, because
    // every output, including rdata and the shared DRP bus, must read 0 in reset.
    if (!drp_rst_n) begin
      trig_q  <= 1'b0;
      armed_q <= 1'b0;
      op_q    <= OP_READ;
      ch_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      di_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      trig_q  <= req_trigger;
      armed_q <= 1'b1;
      if (state_q == S_IDLE && trig_edge) begin
        op_q    <= op_t'(req_op);
        ch_q    <= req_ch;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mask_q  <= req_mask;
        di_q    <= req_wdata;
        err_q   <= req_bad;
      end
      if (state_q == S_RD_WAIT && sel_rdy) begin
        rdata_q <= sel_do;
        di_q    <= (sel_do & ~mask_q) | (wdata_q & mask_q);
      end
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign err          = err_q;
  assign rdata        = rdata_q;
  assign drp.drp_addr = addr_q;
  assign drp.drp_di   = di_q;

endmodule

// File: tb/tb_drp_multi_master.sv
// Testbench for drp_multi_master. A DRP channel responder and a reference
// model of each transaction live here: the accesses, timing, data and error
// expected for each request. Outputs are sampled 1 ns after the rising edge.
module tb_drp_multi_master;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 9;
  localparam int CH_W   = 4;
  localparam int TMO    = 15;

  logic              drp_clk = 1'b0;
  logic              drp_rst_n;
  logic              req_trigger;
  logic [1:0]        req_op;
  logic [CH_W-1:0]   req_ch;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata, req_mask;
  logic              busy, done, err;
  logic [15:0]       rdata;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] rdata_model = 16'h0000;

  typedef struct {
    int                cyc;
    int                ch;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       di;
  } ev_t;
  ev_t evq[$];

  always #5 drp_clk = ~drp_clk;

  drp_multi_master_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) drp ();

  drp_multi_master #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CH_W(CH_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .drp_clk(drp_clk), .drp_rst_n(drp_rst_n),
    .req_trigger(req_trigger), .req_op(req_op), .req_ch(req_ch),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .drp(drp)
  );

  // Issue one request and act as the DRP channels while it runs. Then compare
  // what was observed with the reference model. n1/n2 are the read/write ready
  // delays after en, and a negative value means ready never comes. hold is the
  // cycle at which the trigger drops. glitch_at pulses the trigger low for one
  // cycle, which gives a second edge while the transaction is busy.
  task automatic do_txn(input string name, input logic [1:0] op, input int ch,
                        input logic [ADDR_W-1:0] addr, input logic [15:0] wd,
                        input logic [15:0] mk, input int n1, input int n2,
                        input logic [15:0] rd_val, input bit noise,
                        input int hold, input int glitch_at);
    bit valid, exp_err, err_at_done;
    int exp_done, exp_nev, sched, done_cyc, done_cnt, busy_cnt, bad_bus, evch;
    logic [15:0] exp_rdata, merged;
    logic [63:0] got_ev, exp_ev;
    ev_t ev;

    // Reference model: the accesses, completion cycle, err and rdata expected.
    valid     = (ch < NUM_CH) && (op != 2'b11);
    merged    = (rd_val & ~mk) | (wd & mk);
    exp_rdata = rdata_model;
    exp_err   = 1'b0;
    exp_nev   = 0;
    exp_done  = 1;
    if (!valid) exp_err = 1'b1;
    else if (op == 2'b01) begin
      exp_nev = 1;
      if (n2 < 0) begin exp_done = 2 + TMO; exp_err = 1'b1; end
      else exp_done = 2 + n2;
    end else if (n1 < 0) begin
      exp_nev = 1; exp_done = 2 + TMO; exp_err = 1'b1;
    end else begin
      exp_rdata = rd_val;
      if (op == 2'b00) begin exp_nev = 1; exp_done = 2 + n1; end
      else begin
        exp_nev = 2;
        if (n2 < 0) begin exp_done = 3 + n1 + TMO; exp_err = 1'b1; end
        else exp_done = 3 + n1 + n2;
      end
    end

    sched = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; bad_bus = 0;
    err_at_done = 1'b0;
    evq.delete();
    @(posedge drp_clk); #1;
    req_op = op; req_ch = CH_W'(ch); req_addr = addr; req_wdata = wd; req_mask = mk;
    req_trigger = 1'b1;
    for (int k = 1; k <= hold + 300; k++) begin
      @(posedge drp_clk); #1;
      req_trigger = (k < hold) && (k != glitch_at);
      if (k == 1) begin
        req_op = 2'($urandom); req_ch = CH_W'($urandom); req_addr = ADDR_W'($urandom);
        req_wdata = 16'($urandom); req_mask = 16'($urandom);
      end
      for (int c = 0; c < NUM_CH; c++) drp.drp_do[16*c +: 16] = 16'($urandom);
      drp.drp_rdy = noise ? NUM_CH'($urandom) : '0;
      if (ch < NUM_CH) begin
        drp.drp_rdy[ch] = (k == sched);
        if (k == sched) drp.drp_do[16*ch +: 16] = rd_val;
      end
      if (((drp.drp_we & ~drp.drp_en) != '0) || ($countones(drp.drp_en) > 1)) bad_bus++;
      if (drp.drp_en != '0) begin
        evch = 0;
        for (int c = 0; c < NUM_CH; c++) if (drp.drp_en[c]) evch = c;
        ev.cyc = k; ev.ch = evch; ev.we = drp.drp_we[evch];
        ev.addr = drp.drp_addr; ev.di = drp.drp_di;
        evq.push_back(ev);
        if ((ev.we ? n2 : n1) >= 0) sched = k + (ev.we ? n2 : n1);
        else sched = -1;
        if (noise) drp.drp_rdy[evch] = 1'b1;
      end
      if (done_cyc < 0 && busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = k; err_at_done = err; end
      end
      if (done_cyc >= 0 && k >= done_cyc + 3 && k >= hold) break;
    end
    req_trigger = 1'b0;
    drp.drp_rdy = '0;

    vectors++;
    if (done_cnt !== 1) begin
      miscompares++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
    end
    vectors++;
    if (done_cyc !== exp_done) begin
      miscompares++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done);
    end
    vectors++;
    if (err_at_done !== exp_err) begin
      miscompares++; $display("FAIL %s err_at_done: got %0b want %0b", name, err_at_done, exp_err);
    end
    vectors++;
    if (busy_cnt !== (valid ? exp_done - 1 : 0)) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, valid ? exp_done - 1 : 0);
    end
    vectors++;
    if (bad_bus !== 0) begin
      miscompares++; $display("FAIL %s multi_hot_strobes: got %0d cycles want 0", name, bad_bus);
    end
    vectors++;
    if (evq.size() !== exp_nev) begin
      miscompares++; $display("FAIL %s access_count: got %0d want %0d", name, evq.size(), exp_nev);
    end
    for (int i = 0; i < evq.size() && i < exp_nev; i++) begin
      got_ev = {32'(evq[i].cyc), 8'(evq[i].ch), 7'(evq[i].we), 8'(evq[i].addr), 9'd0};
      exp_ev = {32'((i == 0) ? 1 : 2 + n1), 8'(ch), 7'((op == 2'b01) || (i == 1)), 8'(addr), 9'd0};
      vectors++;
      if (got_ev !== exp_ev || evq[i].addr !== addr) begin
        miscompares++;
        $display("FAIL %s access%0d: got cyc=%0d ch=%0d we=%0b addr=%h want cyc=%0d ch=%0d we=%0b addr=%h",
                 name, i, evq[i].cyc, evq[i].ch, evq[i].we, evq[i].addr,
                 (i == 0) ? 1 : 2 + n1, ch, (op == 2'b01) || (i == 1), addr);
      end
      if (evq[i].we) begin
        vectors++;
        if (evq[i].di !== ((op == 2'b01) ? wd : merged)) begin
          miscompares++;
          $display("FAIL %s write_data: got %h want %h", name, evq[i].di, (op == 2'b01) ? wd : merged);
        end
      end
    end
    vectors++;
    if (rdata !== exp_rdata) begin
      miscompares++; $display("FAIL %s rdata: got %h want %h", name, rdata, exp_rdata);
    end
    vectors++;
    if (err !== exp_err) begin
      miscompares++; $display("FAIL %s err_sticky: got %0b want %0b", name, err, exp_err);
    end
    rdata_model = exp_rdata;
  endtask

  task automatic test_reset();
    int act;
    drp_rst_n = 1'b0;
    req_trigger = 1'b1; req_op = 2'b00; req_ch = 1; req_addr = 9'h011;
    req_wdata = 16'h0; req_mask = 16'h0;
    repeat (3) @(posedge drp_clk);
    #1;
    vectors++;
    if ({busy, done, err, rdata, drp.drp_en, drp.drp_we, drp.drp_addr, drp.drp_di} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b rdata=%h en=%b we=%b addr=%h di=%h want all 0",
               busy, done, err, rdata, drp.drp_en, drp.drp_we, drp.drp_addr, drp.drp_di);
    end
    drp_rst_n = 1'b1;
    act = 0;
    repeat (10) begin
      @(posedge drp_clk); #1;
      if (busy || done || drp.drp_en != '0) act++;
    end
    vectors++;
    if (act !== 0) begin
      miscompares++; $display("FAIL held_through_reset: got %0d active cycles want 0", act);
    end
    req_trigger = 1'b0;
    @(posedge drp_clk); #1;
  endtask

  task automatic test_read();
    do_txn("read_ch2", 2'b00, 2, 9'h07C, 16'h0000, 16'h0000, 3, 1, 16'hBEEF, 1'b0, 1, -1);
  endtask

  task automatic test_write();
    do_txn("write_ch3", 2'b01, 3, 9'h1A5, 16'hC0DE, 16'h0000, 1, 2, 16'h0000, 1'b0, 1, -1);
  endtask

  task automatic test_rmw();
    do_txn("rmw_ch0", 2'b10, 0, 9'h063, 16'h0050, 16'h00F0, 2, 2, 16'h1234, 1'b0, 1, -1);
  endtask

  task automatic test_held_trigger();
    do_txn("held_trigger", 2'b00, 1, 9'h0F0, 16'h0000, 16'h0000, 8, 1, 16'h7E57, 1'b1, 100, 3);
  endtask

  task automatic test_invalid();
    do_txn("bad_channel", 2'b00, NUM_CH, 9'h010, 16'h1111, 16'hFFFF, 1, 1, 16'h2222, 1'b0, 1, -1);
    do_txn("reserved_op", 2'b11, 1, 9'h020, 16'h3333, 16'hFFFF, 1, 1, 16'h4444, 1'b0, 1, -1);
  endtask

`ifdef DRP_TIMEOUT_EN
  task automatic test_timeout();
    do_txn("read_timeout", 2'b00, 1, 9'h033, 16'h0000, 16'h0000, -1, 1, 16'hAAAA, 1'b0, 1, -1);
    do_txn("read_after_timeout", 2'b00, 1, 9'h034, 16'h0000, 16'h0000, 2, 1, 16'h5A5A, 1'b0, 1, -1);
  endtask
`endif

  task automatic test_back_to_back_random();
    logic [1:0] op;
    int ch;
    for (int t = 0; t < 24; t++) begin
      op = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ch = ($urandom_range(0, 7) == 0) ? int'($urandom_range(NUM_CH, 15))
                                       : int'($urandom_range(0, NUM_CH - 1));
      do_txn($sformatf("rand%0d", t), op, ch, ADDR_W'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), 16'($urandom), 1'b1, 1, -1);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge drp_clk); #1;
    req_op = 2'b00; req_ch = 1; req_addr = 9'h055; req_trigger = 1'b1;
    drp.drp_rdy = '0;
    repeat (4) @(posedge drp_clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset_precondition_busy: got %0b want 1", busy);
    end
    #2 drp_rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, err, rdata, drp.drp_en, drp.drp_we} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got busy=%0b done=%0b err=%0b rdata=%h en=%b we=%b want all 0",
               busy, done, err, rdata, drp.drp_en, drp.drp_we);
    end
    rdata_model = 16'h0000;
    req_trigger = 1'b0;
    @(posedge drp_clk); #1;
    drp_rst_n = 1'b1;
    do_txn("read_after_reset", 2'b00, 3, 9'h099, 16'h0000, 16'h0000, 1, 1, 16'h600D, 1'b0, 1, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drp_rst_n = 1'b0;
    req_trigger = 1'b0; req_op = '0; req_ch = '0; req_addr = '0;
    req_wdata = '0; req_mask = '0;
    drp.drp_do = '0; drp.drp_rdy = '0;
    test_reset();
    test_read();
    test_write();
    test_rmw();
    test_held_trigger();
    test_invalid();
`ifdef DRP_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/drp_multi_master.md
Name: drp_multi_master

Overview:
- Parametrised successor to the single-shot DRP trigger logic on the GTH wrapper.
- Issues complete DRP transactions (read, write, read-modify-write) to one of NUM_CH transceiver channels, selected per request.
- Waits for the DRP ready handshake, captures read data, and reports done/error.
- Sits in the free-running DRP clock domain, after the single-bit CDC of the AXI-side trigger.

Parameters:
- NUM_CH, 4, number of GTH channels served (1..16).
- ADDR_W, 9, DRP address width (9 for GTHE3/GTHE4, 10 for GTYE4).
- CH_W, 4, request channel-select width; must satisfy 2**CH_W >= NUM_CH.
- TIMEOUT_CYCLES, 1023, drp_clk cycles to wait for ready before aborting (only used with DRP_TIMEOUT_EN).

Ports:
- drp_clk  in  1  free-running DRP clock; the only clock.
- drp_rst_n  in  1  asynchronous, active-low reset.
- req_trigger  in  1  level request, already synchronised to drp_clk; rising edge starts a transaction.
- req_op  in  2  00 read, 01 write, 10 read-modify-write, 11 reserved.
- req_ch  in  CH_W  target channel index.
- req_addr  in  ADDR_W  DRP address.
- req_wdata  in  16  write data.
- req_mask  in  16  RMW bit mask; 1 = take req_wdata bit.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag for the last transaction.
- rdata  out  16  read data from the last read/RMW.
- drp_en  out  NUM_CH  per-channel DRP enable.
- drp_we  out  NUM_CH  per-channel DRP write enable.
- drp_addr  out  ADDR_W  shared DRP address.
- drp_di  out  16  shared DRP write data.
- drp_do  in  16*NUM_CH  per-channel read data; channel k occupies bits [16k+15:16k].
- drp_rdy  in  NUM_CH  per-channel DRP ready.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; edge-detect register cleared to 0.
  - A trigger held high through reset release is not a rising edge.
- Rising edge of req_trigger: prev=0 and current=1, sampled on drp_clk.
  - Replaces the earlier hysteresis counter.
  - A held-high trigger produces exactly one transaction.
- Request fields are latched on the accepting edge. Changes after acceptance have no effect.
- Rising edge while busy=1: ignored, not queued.
- FSM states: IDLE, RD_EN, RD_WAIT, WR_EN, WR_WAIT, FIN.
- IDLE, on edge:
  - req_ch >= NUM_CH or op=11: go to FIN with err=1, no DRP access.
  - op=00 or 10: go to RD_EN.
  - op=01: go to WR_EN.
  - busy=1 from the cycle after the edge until FIN.
- RD_EN: drp_en[ch]=1 for exactly one cycle, drp_we=0, drp_addr=latched address. Go to RD_WAIT.
- RD_WAIT: wait for drp_rdy[ch]=1, then capture drp_do slice into rdata.
  - op=00: go to FIN.
  - op=10: drp_di = (rdata & ~mask) | (wdata & mask), computed on the captured value, then go to WR_EN.
- WR_EN: drp_en[ch]=drp_we[ch]=1 for one cycle; drp_di = wdata (op 01) or the merged value (op 10). Go to WR_WAIT.
- WR_WAIT: wait for drp_rdy[ch]=1, then go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Latency for a read, with rdy returned N cycles after en (N>=1): edge at cycle 0, en at cycle 1, done at cycle 1+N+1.
- Ready on non-selected channels is ignored.
- Ready seen in the same cycle as en is not accepted; ready is only accepted in the WAIT states.
- err is cleared on acceptance of each new transaction and set by invalid requests or timeout.
- rdata holds its value until the next successful read capture.
- drp_en and drp_we are never asserted on more than one channel in a cycle.
- drp_rst_n asserted mid-transaction: immediate return to IDLE with all outputs 0.
  - The DRP port may be left mid-access; recovery is the GTH's own DRP reset.

Optional Feature:
- Macro DRP_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to RD_WAIT/WR_WAIT and increments each wait cycle.
  - When it reaches TIMEOUT_CYCLES without ready: go to FIN with err=1. rdata is unchanged, and RMW skips its write.
- Undefined: WAIT states wait indefinitely; there is no counter logic.

Test Plan:
- Read ch2, addr 0x07C, rdy after 3 cycles with drp_do[47:32]=0xBEEF -> single drp_en[2] pulse at cycle 1; done at cycle 5; rdata=0xBEEF; err=0.
- RMW ch0, addr 0x063, mask 0x00F0, wdata 0x0050, read returns 0x1234 -> read then write access, drp_di=0x1254 with drp_we[0]=1; one done pulse.
- Trigger held high 100 cycles, plus a second edge while busy -> exactly one transaction and one done.
- req_ch=NUM_CH (4), then op=11 on ch1 -> no drp_en toggles; done with err=1 for each.
- With DRP_TIMEOUT_EN, TIMEOUT_CYCLES=15, rdy never asserted -> done with err=1 at cycle 1+15+1; rdata unchanged. The next valid read clears err.
- drp_rst_n pulsed low during RD_WAIT -> busy, done, err, drp_en and drp_we go to 0 asynchronously; the next edge after release is serviced normally.
